// File: rtl/ising_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | Module   : ising_run_sequencer                                                             |
// | Desc     : Run scheduler for the Ising core: reset -> anneal -> spin readout per run.       |
// | Revision : 1.0 - initial release                                                           |
// +--------------------------------------------------------------------------------------------+
module ising_run_sequencer #(
   parameter int N          = 256,
   parameter int WORD_W     = 32,
   parameter int RST_CYCLES = 4,
   parameter int CNT_W      = 32,
   localparam int c_num_words = N / WORD_W,
   localparam int c_idx_w     = (c_num_words > 1) ? $clog2(c_num_words) : 1
) (
   input  logic               clk_main_a0,
   input  logic               rst_main_n,
   input  logic               cfg_we,
   input  logic [3:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata,
   output logic               core_rstn,
   output logic               core_run,
   output logic               spin_rd_req,
   output logic [c_idx_w-1:0] spin_rd_idx,
   input  logic               spin_rd_ack,
   input  logic [WORD_W-1:0]  spin_rd_data,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WORD_W-1:0]  res_data,
   output logic               res_last,
   output logic               busy,
   output logic               done_pulse
);

   localparam int c_rst_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_crst = 3'd1;
   localparam logic [2:0] c_st_run  = 3'd2;
   localparam logic [2:0] c_st_sreq = 3'd3;
   localparam logic [2:0] c_st_sout = 3'd4;
   localparam logic [2:0] c_st_next = 3'd5;

   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_words - 1);
   localparam logic [c_rst_w-1:0] c_rst_init = c_rst_w'(RST_CYCLES - 1);

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [c_rst_w-1:0] r_rst_cnt;
   logic [CNT_W-1:0]   r_anneal_cnt;
   logic [CNT_W-1:0]   r_anneal_cyc;
   logic [c_idx_w-1:0] r_idx;
   logic [WORD_W-1:0]  r_word;
   logic [15:0]        r_num_runs;
   logic [15:0]        r_runs_done;
   logic               r_done_flag;
   logic               r_done_pulse;
   logic               r_out_of_reset;
   logic [31:0]        r_rdata;
   logic [31:0]        w_rdata;
   logic [31:0]        w_anneal_rd;
   logic [CNT_W-1:0]   w_anneal_wr;

   logic w_ctrl_wr, w_start, w_abort, w_busy, w_last_word, w_last_run;

   assign w_ctrl_wr   = cfg_we && (cfg_addr == 4'h0);
   assign w_abort     = w_ctrl_wr && cfg_wdata[1];
   assign w_start     = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
   assign w_busy      = (r_state != c_st_idle);
   assign w_last_word = (r_idx == c_last_idx);
   assign w_last_run  = ((17'(r_runs_done) + 17'd1) == 17'(r_num_runs));

   generate
      if (CNT_W >= 32) begin : g_anneal_wide
         assign w_anneal_rd = r_anneal_cyc[31:0];
         assign w_anneal_wr = CNT_W'(cfg_wdata);
      end else begin : g_anneal_narrow
         assign w_anneal_rd = {{(32-CNT_W){1'b0}}, r_anneal_cyc};
         assign w_anneal_wr = cfg_wdata[CNT_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) r_state <= c_st_idle;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_abort && w_busy) begin
         w_state_nxt = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle: if (w_start && (r_num_runs != 16'd0)) w_state_nxt = c_st_crst;
            c_st_crst: if (r_rst_cnt == '0)                  w_state_nxt = c_st_run;
            c_st_run:  if (r_anneal_cnt == '0)               w_state_nxt = c_st_sreq;
            c_st_sreq: if (spin_rd_ack)                      w_state_nxt = c_st_sout;
            c_st_sout: if (res_ready) w_state_nxt = w_last_word ? c_st_next : c_st_sreq;
            c_st_next: w_state_nxt = w_last_run ? c_st_idle : c_st_crst;
            default:   w_state_nxt = c_st_idle;
         endcase
      end
   end

   // Outputs the core and result buffer see drop in the abort cycle itself.
   always_comb begin
      core_rstn   = r_out_of_reset && (r_state != c_st_crst);
      core_run    = (r_state == c_st_run)  && !w_abort;
      spin_rd_req = (r_state == c_st_sreq) && !w_abort;
      res_valid   = (r_state == c_st_sout) && !w_abort;
      res_last    = (r_state == c_st_sout) && w_last_word;
      done_pulse  = r_done_pulse || ((r_state == c_st_next) && w_last_run && !w_abort);
   end

   assign spin_rd_idx = r_idx;
   assign res_data    = r_word;
   assign busy        = w_busy;
   assign cfg_rdata   = r_rdata;

   always_comb begin
      w_rdata = 32'd0;
      case (cfg_addr)
         4'h4:    w_rdata = {16'd0, r_num_runs};
         4'h8:    w_rdata = w_anneal_rd;
         4'hC:    w_rdata = {r_done_flag, w_busy, 14'd0, r_runs_done};
         default: w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         r_out_of_reset <= 1'b0;
         r_rst_cnt      <= '0;
         r_anneal_cnt   <= '0;
         r_anneal_cyc   <= CNT_W'(1000);
         r_idx          <= '0;
         r_word         <= '0;
         r_num_runs     <= 16'd1;
         r_runs_done    <= 16'd0;
         r_done_flag    <= 1'b0;
         r_done_pulse   <= 1'b0;
         r_rdata        <= 32'd0;
      end else begin
         r_out_of_reset <= 1'b1;
         r_done_pulse   <= 1'b0;
         r_rdata        <= w_rdata;
         if (cfg_we && !w_busy) begin
            if (cfg_addr == 4'h4) r_num_runs   <= cfg_wdata[15:0];
            if (cfg_addr == 4'h8) r_anneal_cyc <= w_anneal_wr;
         end
         case (r_state)
            c_st_idle: begin
               if (w_start && (r_num_runs != 16'd0)) begin
                  r_runs_done <= 16'd0;
                  r_done_flag <= 1'b0;
                  r_rst_cnt   <= c_rst_init;
               end else if (w_start) begin
                  r_done_flag  <= 1'b1;
                  r_done_pulse <= 1'b1;
               end
            end
            c_st_crst: begin
               if (r_rst_cnt == '0) r_anneal_cnt <= r_anneal_cyc;
               else                 r_rst_cnt    <= r_rst_cnt - c_rst_w'(1);
            end
            c_st_run: begin
               if (r_anneal_cnt == '0) r_idx        <= '0;
               else                    r_anneal_cnt <= r_anneal_cnt - CNT_W'(1);
            end
            c_st_sreq: if (spin_rd_ack) r_word <= spin_rd_data;
            c_st_sout: if (res_ready && !w_last_word) r_idx <= r_idx + c_idx_w'(1);
            c_st_next: begin
               if (r_runs_done != 16'hFFFF) r_runs_done <= r_runs_done + 16'd1;
               if (w_last_run && !w_abort)  r_done_flag <= 1'b1;
               if (!w_last_run)             r_rst_cnt   <= c_rst_init;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
